terminal_qsys_switch_ctrl: RTL

// - Avalon-MM slave controller for the board slide switches.
// - Synchronises and debounces in_port, then exposes the debounced level.
// - Latches per-bit change events in an edge-capture register and raises a maskable irq.
// - Sits between the switch pins and the Qsys interconnect, with one instance per switch bank.

---
 rtl/terminal_qsys_switch_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/terminal_qsys_switch_ctrl.sv
// Avalon-MM slave for one bank of slide switches: synchronise, debounce, per-bit edge capture, maskable irq.
// Debounce is built only when SWITCHES_DEBOUNCE_EN is defined; otherwise the synchronised level is used directly.
module terminal_qsys_switch_ctrl #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipselect,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  // Bus handshake: a transfer completes on every clk edge where chipselect is high together with
  // read or write (no wait states); read data is valid on readdata the cycle after the strobe.
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;
  logic [WIDTH-1:0] debounced;
  logic [WIDTH-1:0] deb_next;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] irq_mask_next;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] edge_cap_next;
  logic [WIDTH-1:0] edge_set;
  logic [31:0]      rd_mux;
  logic             primed;
  logic             load;
  logic             wr_mask;
  logic             wr_edge;
  logic             unused_bits;

  assign unused_bits = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= in_port;
      sync_q2 <= sync_q1;
    end
  end

`ifdef SWITCHES_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] snap;

  // Any movement of the synchronised level restarts the stability count; the counter parks at its
  // last value so a stable level keeps reloading debounced with the same value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      snap <= '0;
    end else if (sync_q2 != snap) begin
      snap <= sync_q2;
      cnt  <= '0;
    end else if (cnt != CNT_LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign load     = (sync_q2 == snap) && (cnt == CNT_LAST);
  assign deb_next = load ? snap : debounced;
`else
  localparam int UNUSED_CFG = DEBOUNCE_CYCLES + CNT_W;

  assign load     = 1'b1;
  assign deb_next = sync_q2;
`endif

  // Edges are taken from the incoming value so the very first load (power-up level) is never captured.
  assign edge_set      = primed ? (deb_next ^ debounced) : '0;
  assign wr_mask       = chipselect && write && (address == ADDR_MASK);
  assign wr_edge       = chipselect && write && (address == ADDR_EDGE);
  assign edge_cap_next = (wr_edge ? (edge_cap & ~writedata[WIDTH-1:0]) : edge_cap) | edge_set;
  assign irq_mask_next = wr_mask ? writedata[WIDTH-1:0] : irq_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      debounced <= '0;
      primed    <= 1'b0;
      edge_cap  <= '0;
      irq_mask  <= '0;
      irq       <= 1'b0;
    end else begin
      debounced <= deb_next;
      primed    <= primed | load;
      edge_cap  <= edge_cap_next;
      irq_mask  <= irq_mask_next;
      irq       <= |(edge_cap_next & irq_mask_next);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = debounced;
      ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_cap;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else if (chipselect && read) begin
      readdata <= rd_mux;
    end
  end

endmodule
